// File: rtl/inv_bist_sequencer_pkg.sv
// Shared state encodings and sizing helpers for the hex-inverter BIST sequencer.
package inv_bist_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  // Width of a vector index covering all 2*N+2 test vectors.
  function automatic int vec_w(input int n_gates);
    return $clog2(2 * n_gates + 2);
  endfunction

endpackage

// File: rtl/inv_bist_sequencer_if.sv
// Bundle between sequencer, board test controller and inverter package.
interface inv_bist_sequencer_if
  import inv_bist_sequencer_pkg::*;
#(
  parameter int N_GATES = 6
) ();

  localparam int VEC_W = vec_w(N_GATES);

  logic               START;
  logic [N_GATES-1:0] DUT_Y;
  logic [N_GATES-1:0] DUT_A;
  logic               BUSY;
  logic               DONE;
  logic               PASS;
  logic [VEC_W-1:0]   FAIL_VEC;
  logic [N_GATES-1:0] FAIL_MASK;

  modport master (
    input  START, DUT_Y,
    output DUT_A, BUSY, DONE, PASS, FAIL_VEC, FAIL_MASK
  );

  modport slave (
    output START, DUT_Y,
    input  DUT_A, BUSY, DONE, PASS, FAIL_VEC, FAIL_MASK
  );

endinterface

// File: rtl/inv_bist_patgen.sv
// Combinational test-vector ROM: all-0, all-1, walking one, walking zero.
module inv_bist_patgen #(
  parameter int N_GATES = 6,
  parameter int VEC_W   = 4
) (
  input  logic [VEC_W-1:0]   vec_idx_i,
  output logic [N_GATES-1:0] vec_o
);

  localparam logic [N_GATES-1:0] ONE = N_GATES'(1);

  int idx;

  always_comb begin
    idx   = int'(vec_idx_i);
    vec_o = '0;
    if (idx == 0) begin
      vec_o = '0;
    end else if (idx == 1) begin
      vec_o = '1;
    end else if (idx < 2 + N_GATES) begin
      vec_o = ONE << (idx - 2);
    end else if (idx < 2 + 2 * N_GATES) begin
      vec_o = ~(ONE << (idx - 2 - N_GATES));
    end
  end

endmodule

// File: rtl/inv_bist_sequencer.sv
// BIST sequencer: drives each vector onto the inverter inputs for SETTLE+1 cycles,
// checks Y == ~A on the last cycle, aborts on the first mismatch and holds the result.
module inv_bist_sequencer
  import inv_bist_sequencer_pkg::*;
#(
  parameter int N_GATES = 6,
  parameter int SETTLE  = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  inv_bist_sequencer_if.master bus
);

  localparam int VEC_W = vec_w(N_GATES);
  localparam int NV    = 2 * N_GATES + 2;

  state_e             state_q, state_d;
  logic [VEC_W-1:0]   vec_idx_q, vec_idx_d;
  logic [3:0]         settle_cnt_q, settle_cnt_d;
  logic [N_GATES-1:0] dut_a_q, dut_a_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic [VEC_W-1:0]   fail_vec_q, fail_vec_d;
  logic [N_GATES-1:0] fail_mask_q, fail_mask_d;
  logic [N_GATES-1:0] pat_vec;
  logic [N_GATES-1:0] mismatch;

  inv_bist_patgen #(
    .N_GATES (N_GATES),
    .VEC_W   (VEC_W)
  ) u_patgen (
    .vec_idx_i (vec_idx_d),
    .vec_o     (pat_vec)
  );

  // Case-inequality so an X/Z on a gate output is reported as a fault.
  always_comb begin
    mismatch = '0;
    for (int i = 0; i < N_GATES; i++) begin
      mismatch[i] = (bus.DUT_Y[i] !== ~dut_a_q[i]);
    end
  end

  always_comb begin
    state_d      = state_q;
    vec_idx_d    = vec_idx_q;
    settle_cnt_d = settle_cnt_q;
    done_d       = done_q;
    pass_d       = pass_q;
    fail_vec_d   = fail_vec_q;
    fail_mask_d  = fail_mask_q;
    dut_a_d      = '0;

    case (state_q)
      ST_IDLE, ST_FIN: begin
        if (bus.START) begin
          state_d      = ST_RUN;
          vec_idx_d    = '0;
          settle_cnt_d = '0;
          done_d       = 1'b0;
          pass_d       = 1'b0;
          fail_vec_d   = '0;
          fail_mask_d  = '0;
        end
      end
      ST_RUN: begin
        if (settle_cnt_q == 4'(SETTLE)) begin
          if (mismatch != '0) begin
            state_d     = ST_FIN;
            done_d      = 1'b1;
            pass_d      = 1'b0;
            fail_vec_d  = vec_idx_q;
            fail_mask_d = mismatch;
          end else if (vec_idx_q == VEC_W'(NV - 1)) begin
            state_d     = ST_FIN;
            done_d      = 1'b1;
            pass_d      = 1'b1;
            fail_vec_d  = '0;
            fail_mask_d = '0;
          end else begin
            vec_idx_d    = vec_idx_q + VEC_W'(1);
            settle_cnt_d = '0;
          end
        end else begin
          settle_cnt_d = settle_cnt_q + 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Vector for the upcoming cycle is registered so DUT_A is glitch-free.
    if (state_d == ST_RUN) begin
      dut_a_d = pat_vec;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      vec_idx_q    <= '0;
      settle_cnt_q <= '0;
      dut_a_q      <= '0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_vec_q   <= '0;
      fail_mask_q  <= '0;
    end else begin
      state_q      <= state_d;
      vec_idx_q    <= vec_idx_d;
      settle_cnt_q <= settle_cnt_d;
      dut_a_q      <= dut_a_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      fail_vec_q   <= fail_vec_d;
      fail_mask_q  <= fail_mask_d;
    end
  end

  assign bus.DUT_A     = dut_a_q;
  assign bus.BUSY      = (state_q == ST_RUN);
  assign bus.DONE      = done_q;
  assign bus.PASS      = pass_q;
  assign bus.FAIL_VEC  = fail_vec_q;
  assign bus.FAIL_MASK = fail_mask_q;

endmodule

// File: doc/inv_bist_sequencer.md
Name: inv_bist_sequencer

Overview:
Built-in self-test sequencer for a hex inverter package built from MOD_74x04_1 gates. On START it drives a fixed set of test vectors onto the six inverter inputs and waits a settle window. It then checks every output against the bitwise inverse of its input and reports pass/fail, the first failing vector and the failing gate mask. It sits between the board-level test controller and the inverter package, and owns the package inputs while BUSY.

Parameters:
N_GATES, 6, number of inverter gates under test (1..8)
SETTLE, 2, extra cycles each vector is held before compare (0..15)

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  synchronous active-high reset
START  input  1  one-cycle request to begin a test run
DUT_Y  input  N_GATES  inverter outputs Y[i]
DUT_A  output  N_GATES  inverter inputs A[i]
BUSY  output  1  run in progress
DONE  output  1  run finished; result valid
PASS  output  1  all vectors matched; valid only while DONE=1
FAIL_VEC  output  VEC_W  index of first failing vector; VEC_W = clog2(2*N_GATES+2)
FAIL_MASK  output  N_GATES  bits where DUT_Y != ~DUT_A at the failing compare

Behaviour:
- Single clock CLK; reset synchronous, active-high on RST. All state is updated on the rising edge.
- Reset values: DUT_A=0, BUSY=0, DONE=0, PASS=0, FAIL_VEC=0, FAIL_MASK=0, state=IDLE, vec_idx=0, settle_cnt=0.
- Vector set, NV = 2*N_GATES+2 entries, fixed order:
  - v0 = all 0.
  - v1 = all 1.
  - v(2+i) = walking one (1<<i), for i=0..N_GATES-1.
  - v(2+N_GATES+i) = walking zero (~(1<<i)), masked to N_GATES bits.
  - N_GATES=6 gives 14 vectors; v13 = 6'b011111.
- States: IDLE, RUN, FIN.
- IDLE:
  - DUT_A=0, BUSY=0.
  - START=1 -> RUN, vec_idx=0, settle_cnt=0, DONE/PASS/FAIL_VEC/FAIL_MASK cleared.
- RUN:
  - DUT_A = v[vec_idx], registered; BUSY=1.
  - settle_cnt counts 0..SETTLE. Compare happens on the cycle where settle_cnt==SETTLE, so each vector is held SETTLE+1 cycles.
  - Compare: mismatch = DUT_Y ^ ~DUT_A (N_GATES bits).
  - mismatch != 0 -> FIN, PASS=0, FAIL_VEC=vec_idx, FAIL_MASK=mismatch. The run aborts on the first failure.
  - mismatch == 0 and vec_idx==NV-1 -> FIN, PASS=1, FAIL_MASK=0, FAIL_VEC=0.
  - Otherwise vec_idx+1 and settle_cnt=0.
  - START while in RUN is ignored.
- FIN:
  - DONE=1, BUSY=0, DUT_A=0. Results are held until the next START or RST.
  - START in FIN behaves as START in IDLE: clear results and begin a new run the next cycle.
- Latency: START sampled at edge k.
  - BUSY=1 and DUT_A=v0 from edge k+1.
  - Passing run: DONE=1 at edge k+1+NV*(SETTLE+1), i.e. k+43 with defaults.
  - Failing run at vector j: DONE=1 at edge k+1+(j+1)*(SETTLE+1).
- RST mid-run has priority over everything: next cycle is IDLE with all reset values; no partial result is kept.
- START and RST asserted in the same cycle: RST wins.
- X/Z on DUT_Y at the compare cycle counts as a mismatch (case-inequality compare).

Decomposition:
- Shared include/package inv_bist_defs: state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_FIN=2'd2; the VEC_W width function.
- One natural sub-module: inv_bist_patgen, purely combinational, mapping vec_idx to the vector (parameter N_GATES). The sequencer registers its output onto DUT_A.

Test Plan:
- Healthy DUT, defaults: six MOD_74x04_1 instances, pulse START at cycle 5 -> BUSY 6..47; DONE=1, PASS=1 at 48; DUT_A walks 000000, 111111, 000001 .. 100000, 111110 .. 011111.
- Stuck-at-0 on gate 3 (Y[3] tied 0) -> fails at v0 (A=0, expected Y=111111): FAIL_VEC=0, FAIL_MASK=6'b001000, PASS=0, DONE 3 cycles after BUSY rises.
- Stuck-at-1 on gate 0 -> v0 and v1 are checked, fails at v1: FAIL_VEC=1, FAIL_MASK=6'b000001, PASS=0, DONE 6 cycles after BUSY rises.
- Bridged outputs Y[2]=Y[4]=AND of both -> fails at v4 (A=000100, Y=111011 expected, 101011 seen): FAIL_VEC=4, FAIL_MASK=6'b010000.
- RST asserted at 10th RUN cycle -> next cycle BUSY=0, DONE=0, DUT_A=0; a START 3 cycles later gives a full passing run from v0.
- START pulsed again during RUN: no effect, DONE timing unchanged. START pulsed in FIN: DONE drops next cycle and a new run starts. SETTLE=0 build: passing run DONE at k+15.
